// File: rtl/lbrs_pkg.sv
// rtl/lbrs_pkg.sv - shared types and widths for the line buffer row scheduler
package lbrs_pkg;

    localparam int IMG_W = 8;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_CMD, S_WAIT, S_FIN} state_t;
    typedef enum logic [1:0] {RK_FIRST, RK_MID, RK_LAST} row_kind_t;

    function automatic row_kind_t row_kind(input logic [IMG_W-1:0] row,
                                           input logic [IMG_W-1:0] img);
        if (row == '0)
            return RK_FIRST;
        if (row == img)
            return RK_LAST;
        return RK_MID;
    endfunction

endpackage

// File: rtl/lbrs_addr_gen.sv
// rtl/lbrs_addr_gen.sv - multiplier-free rd_addr generator (channel base + row offset accumulators)
module lbrs_addr_gen
    import lbrs_pkg::*;
#(
    parameter int ADDR_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  clear,
    input  logic                  next_row,
    input  logic                  next_ch,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [IMG_W-1:0]      img_size,
    output logic [ADDR_WIDTH-1:0] rd_addr
);

    logic [ADDR_WIDTH-1:0] row_base;
    logic [ADDR_WIDTH-1:0] ch_base;

    // row_base reaches IMAGE_SIZE^2 at the last row, so it is the channel stride
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            row_base <= '0;
            ch_base  <= '0;
        end else if (clear) begin
            row_base <= '0;
            ch_base  <= base_addr;
        end else if (next_ch) begin
            row_base <= '0;
            ch_base  <= ch_base + row_base;
        end else if (next_row) begin
            row_base <= row_base + ADDR_WIDTH'(img_size);
        end
    end

    assign rd_addr = ch_base + row_base;

endmodule

// File: rtl/line_buffer_row_scheduler.sv
// rtl/line_buffer_row_scheduler.sv - per-row command and DMA request sequencer; optional LBRS_WATCHDOG_EN
module line_buffer_row_scheduler
    import lbrs_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter int CH_WIDTH   = 9,
    parameter int WDT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [IMG_W-1:0]      IMAGE_SIZE,
    input  logic [CH_WIDTH-1:0]   CHANNEL_SIZE,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  Done_1row,
    input  logic                  rd_ready,
    output logic                  Stream_first_row,
    output logic                  Stream_mid_row,
    output logic                  Stream_last_row,
    output logic                  last_channel,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [IMG_W-1:0]      rd_len,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    state_t              state, state_n;
    logic [IMG_W-1:0]    img_q, row, row_n;
    logic [CH_WIDTH-1:0] nch_q, ch, ch_n;
    logic                accept, clear, next_row, next_ch, cfg_set, cfg_clr, wdt_hit;
    row_kind_t           kind;

`ifdef LBRS_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    logic [WDT_W-1:0] wdt;

    assign wdt_hit = (state == S_REQ || state == S_WAIT) && wdt == WDT_W'(WDT_CYCLES - 1);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)
            wdt <= '0;
        else if (state_n != state)
            wdt <= '0;
        else if (!wdt_hit)
            wdt <= wdt + WDT_W'(1);
    end
`else
    // watchdog compiled out: constant false
    assign wdt_hit = (WDT_CYCLES < 0);
`endif

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state   <= S_IDLE;
            img_q   <= '0;
            nch_q   <= '0;
            row     <= '0;
            ch      <= '0;
            cfg_err <= 1'b0;
        end else begin
            state <= state_n;
            row   <= row_n;
            ch    <= ch_n;
            if (accept) begin
                img_q <= IMAGE_SIZE;
                nch_q <= CHANNEL_SIZE;
            end
            if (cfg_set)
                cfg_err <= 1'b1;
            else if (cfg_clr)
                cfg_err <= 1'b0;
        end
    end

    always_comb begin
        state_n  = state;
        row_n    = row;
        ch_n     = ch;
        accept   = 1'b0;
        clear    = 1'b0;
        next_row = 1'b0;
        next_ch  = 1'b0;
        cfg_set  = 1'b0;
        cfg_clr  = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                if (IMAGE_SIZE >= IMG_W'(2) && CHANNEL_SIZE != '0) begin
                    accept  = 1'b1;
                    clear   = 1'b1;
                    cfg_clr = 1'b1;
                    row_n   = '0;
                    ch_n    = '0;
                    state_n = S_REQ;
                end else begin
                    cfg_set = 1'b1;
                end
            end
            S_REQ:  if (rd_ready) state_n = S_CMD;
            S_CMD:  state_n = S_WAIT;
            S_WAIT: if (Done_1row) begin
                if (row != img_q) begin
                    row_n    = row + IMG_W'(1);
                    next_row = 1'b1;
                    state_n  = (row + IMG_W'(1) != img_q) ? S_REQ : S_CMD;
                end else if (ch == nch_q - CH_WIDTH'(1)) begin
                    state_n = S_FIN;
                end else begin
                    row_n   = '0;
                    ch_n    = ch + CH_WIDTH'(1);
                    next_ch = 1'b1;
                    state_n = S_REQ;
                end
            end
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (wdt_hit) begin
            state_n  = S_FIN;
            cfg_set  = 1'b1;
            row_n    = row;
            ch_n     = ch;
            next_row = 1'b0;
            next_ch  = 1'b0;
        end
    end

    lbrs_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk       (clk),
        .Reset     (Reset),
        .clear     (clear),
        .next_row  (next_row),
        .next_ch   (next_ch),
        .base_addr (base_addr),
        .img_size  (IMAGE_SIZE),
        .rd_addr   (rd_addr)
    );

    assign kind             = row_kind(row, img_q);
    assign Stream_first_row = (state == S_CMD) && (kind == RK_FIRST);
    assign Stream_mid_row   = (state == S_CMD) && (kind == RK_MID);
    assign Stream_last_row  = (state == S_CMD) && (kind == RK_LAST);
    assign rd_valid         = (state == S_REQ);
    assign rd_len           = img_q;
    assign busy             = (state != S_IDLE) && (state != S_FIN);
    assign done             = (state == S_FIN);
    assign last_channel     = busy && (ch == nch_q - CH_WIDTH'(1));

endmodule

// File: tb/tb_line_buffer_row_scheduler.sv
// tb/tb_line_buffer_row_scheduler.sv - table-driven bench for line_buffer_row_scheduler
module tb_line_buffer_row_scheduler;

    localparam int AW   = 24;
    localparam int CW   = 9;
    localparam int NEXP = 29;

    logic          clk = 1'b0;
    logic          Reset, start, Done_1row, rd_ready;
    logic [7:0]    IMAGE_SIZE;
    logic [CW-1:0] CHANNEL_SIZE;
    logic [AW-1:0] base_addr;
    logic          Stream_first_row, Stream_mid_row, Stream_last_row, last_channel;
    logic          rd_valid, busy, done, cfg_err;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_len;

    always #5 clk = ~clk;

    line_buffer_row_scheduler #(.ADDR_WIDTH(AW), .CH_WIDTH(CW), .WDT_CYCLES(16)) dut (
        .clk              (clk),
        .Reset            (Reset),
        .start            (start),
        .IMAGE_SIZE       (IMAGE_SIZE),
        .CHANNEL_SIZE     (CHANNEL_SIZE),
        .base_addr        (base_addr),
        .Done_1row        (Done_1row),
        .rd_ready         (rd_ready),
        .Stream_first_row (Stream_first_row),
        .Stream_mid_row   (Stream_mid_row),
        .Stream_last_row  (Stream_last_row),
        .last_channel     (last_channel),
        .rd_valid         (rd_valid),
        .rd_addr          (rd_addr),
        .rd_len           (rd_len),
        .busy             (busy),
        .done             (done),
        .cfg_err          (cfg_err)
    );

    typedef struct {
        int          kind;
        logic [AW-1:0] addr;
        logic        lc;
    } exp_t;

    exp_t          tbl [NEXP];
    int            n_pass = 0;
    int            n_total = 0;
    int            exp_idx, n_cmd, done_cnt;
    logic [AW-1:0] last_req;
    logic          have_req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic set_exp(input int i, input int k, input logic [AW-1:0] a, input logic l);
        tbl[i].kind = k;
        tbl[i].addr = a;
        tbl[i].lc   = l;
    endtask

    task automatic do_start(input logic [7:0] img, input logic [CW-1:0] nch, input logic [AW-1:0] base);
        IMAGE_SIZE   = img;
        CHANNEL_SIZE = nch;
        base_addr    = base;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        start     = 1'b0;
        Done_1row = 1'b0;
        @(negedge clk);
        Reset     = 1'b0;
        @(negedge clk);
    endtask

    // Acts as DMA (always ready) and line buffer (Done_1row 3 cycles after each command).
    task automatic run_cmds(input int max_cmds);
        bit   fin;
        int   guard, cnt, npulse, kind, idx;
        fin      = 1'b0;
        guard    = 0;
        cnt      = 0;
        have_req = 1'b0;
        while (!fin) begin
            Done_1row = 1'b0;
            if (rd_valid && rd_ready) begin
                last_req = rd_addr;
                have_req = 1'b1;
            end
            npulse = int'(Stream_first_row) + int'(Stream_mid_row) + int'(Stream_last_row);
            kind   = Stream_first_row ? 0 : (Stream_mid_row ? 1 : 2);
            if (npulse > 1)
                check("onehot_cmd", npulse, 1);
            if (npulse == 1) begin
                idx = (exp_idx < NEXP) ? exp_idx : NEXP - 1;
                if (exp_idx >= NEXP)
                    check("cmd_beyond_table", exp_idx, NEXP - 1);
                check($sformatf("cmd%0d_kind", exp_idx), kind, tbl[idx].kind);
                check($sformatf("cmd%0d_last_channel", exp_idx), last_channel, tbl[idx].lc);
                if (kind == 2)
                    check($sformatf("cmd%0d_no_req_before_last", exp_idx), have_req, 0);
                else
                    check($sformatf("cmd%0d_rd_addr", exp_idx), have_req ? last_req : 'hFFFFFFFF, tbl[idx].addr);
                have_req = 1'b0;
                exp_idx++;
                n_cmd++;
                cnt = 3;
                if (n_cmd == max_cmds)
                    fin = 1'b1;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0)
                    Done_1row = 1'b1;
            end
            if (done) begin
                done_cnt++;
                check("busy_low_at_done", busy, 0);
                fin = 1'b1;
            end
            if (!fin) begin
                @(negedge clk);
                guard++;
                if (guard > 3000) begin
                    check("run_timeout", 0, 1);
                    fin = 1'b1;
                end
            end
        end
        Done_1row = 1'b0;
    endtask

    initial begin
        int  extra;
        bit  stable;
        set_exp(0, 0, 'h000, 1); set_exp(1, 1, 'h004, 1); set_exp(2, 1, 'h008, 1);
        set_exp(3, 1, 'h00C, 1); set_exp(4, 2, 'h000, 1);
        set_exp(5, 0, 'h100, 0); set_exp(6, 1, 'h104, 0); set_exp(7, 1, 'h108, 0);
        set_exp(8, 1, 'h10C, 0); set_exp(9, 2, 'h000, 0);
        set_exp(10, 0, 'h110, 0); set_exp(11, 1, 'h114, 0); set_exp(12, 1, 'h118, 0);
        set_exp(13, 1, 'h11C, 0); set_exp(14, 2, 'h000, 0);
        set_exp(15, 0, 'h120, 1); set_exp(16, 1, 'h124, 1); set_exp(17, 1, 'h128, 1);
        set_exp(18, 1, 'h12C, 1); set_exp(19, 2, 'h000, 1);
        set_exp(20, 0, 'h000, 0); set_exp(21, 1, 'h004, 0); set_exp(22, 1, 'h008, 0);
        set_exp(23, 1, 'h00C, 0); set_exp(24, 2, 'h000, 0);
        set_exp(25, 0, 'h010, 1); set_exp(26, 1, 'h014, 1); set_exp(27, 1, 'h018, 1);
        set_exp(28, 0, 'h000, 1);

        Reset = 1'b1; start = 1'b0; Done_1row = 1'b0; rd_ready = 1'b1;
        IMAGE_SIZE = '0; CHANNEL_SIZE = '0; base_addr = '0;
        @(negedge clk);
        check("reset_outputs", {Stream_first_row, Stream_mid_row, Stream_last_row, last_channel,
                                rd_valid, busy, done, cfg_err, rd_len}, 0);
        check("reset_rd_addr", rd_addr, 0);
        Reset = 1'b0;
        @(negedge clk);

        // 1: single channel, 4x4
        exp_idx = 0; n_cmd = 0; done_cnt = 0;
        do_start(8'd4, 9'd1, 24'h0);
        check("t1_busy", busy, 1);
        check("t1_rd_len", rd_len, 4);
        run_cmds(100);
        check("t1_cmd_count", n_cmd, 5);
        check("t1_done_count", done_cnt, 1);
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            extra += int'(done) + int'(busy);
        end
        check("t1_quiet_after_done", extra, 0);

        // 2: three channels, base 0x100
        exp_idx = 5; n_cmd = 0; done_cnt = 0;
        do_start(8'd4, 9'd3, 24'h100);
        run_cmds(100);
        check("t2_cmd_count", n_cmd, 15);
        check("t2_done_count", done_cnt, 1);
        @(negedge clk);
        check("t2_last_channel_idle", last_channel, 0);

        // 3: DMA stalls the request for 10 cycles
        rd_ready = 1'b0;
        do_start(8'd2, 9'd1, 24'h40);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!rd_valid || rd_addr != 24'h40 || rd_len != 8'd2 ||
                Stream_first_row || Stream_mid_row || Stream_last_row)
                stable = 1'b0;
            @(negedge clk);
        end
        check("t3_req_stable_no_cmd", stable, 1);
        rd_ready = 1'b1;
        @(negedge clk);
        check("t3_first_after_handshake", {Stream_first_row, rd_valid}, 2'b10);
        do_reset();

        // 4: bad configurations
        do_start(8'd1, 9'd1, 24'h0);
        check("t4_img1_cfg_err", cfg_err, 1);
        check("t4_img1_idle", {busy, rd_valid, done}, 0);
        do_start(8'd4, 9'd0, 24'h0);
        check("t4_ch0_cfg_err", cfg_err, 1);
        check("t4_ch0_idle", {busy, rd_valid}, 0);
        do_start(8'd2, 9'd1, 24'h0);
        check("t4_valid_clears_err", {cfg_err, busy}, 2'b01);
        do_reset();

        // 5: reset during WAIT of ch1 row2
        exp_idx = 20; n_cmd = 0; done_cnt = 0;
        do_start(8'd4, 9'd2, 24'h0);
        run_cmds(8);
        @(negedge clk);
        check("t5_in_wait_busy", {busy, rd_valid, last_channel}, 3'b101);
        Reset = 1'b1;
        #1;
        check("t5_reset_outputs", {Stream_first_row, Stream_mid_row, Stream_last_row, last_channel,
                                   rd_valid, busy, done, cfg_err, rd_len}, 0);
        check("t5_reset_rd_addr", rd_addr, 0);
        @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        check("t5_no_done", done_cnt, 0);
        exp_idx = 28; n_cmd = 0;
        do_start(8'd4, 9'd1, 24'h0);
        run_cmds(1);
        do_reset();

`ifdef LBRS_WATCHDOG_EN
        // 6: Done_1row never arrives
        begin
            int w;
            do_start(8'd4, 9'd1, 24'h0);
            w = 0;
            while (!Stream_first_row && w < 50) begin
                @(negedge clk);
                w++;
            end
            check("t6_first_cmd_seen", Stream_first_row, 1);
            w = 0;
            while (!done && w < 100) begin
                @(negedge clk);
                w++;
            end
            check("t6_cmd_to_done_cycles", w, 17);
            check("t6_cfg_err_busy", {cfg_err, busy}, 2'b10);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
